// File: rtl/emif_avmm_bridge_mcs_if.sv
`default_nettype none
// ============================================================================
// Module   : emif_avmm_bridge_mcs_if
// Purpose  : Avalon-MM master-side bundle used by the EMIF bridge.
//            The address is a byte address {cs_idx, word_addr, zeros}. Its
//            width is derived from the same parameters as the bridge.
// Modports : master - bridge side (drives requests, receives responses)
//            slave  - interconnect / memory side
// Revision : 1.0 - initial release
// ============================================================================
interface emif_avmm_bridge_mcs_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 24,
    parameter int CS_NUM = 1
);
    localparam int BE_W       = DATA_W / 8;
    localparam int CS_W       = (CS_NUM > 1) ? $clog2(CS_NUM) : 0;
    localparam int AVM_ADDR_W = CS_W + ADDR_W + $clog2(BE_W);

    logic [AVM_ADDR_W-1:0] avm_address;
    logic                  avm_read;
    logic                  avm_write;
    logic [BE_W-1:0]       avm_byteenable;
    logic [DATA_W-1:0]     avm_writedata;
    logic [DATA_W-1:0]     avm_readdata;
    logic                  avm_readdatavalid;
    logic                  avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/emif_avmm_bridge_mcs.sv
`default_nettype none
// ============================================================================
// Module   : emif_avmm_bridge_mcs
// Purpose  : EMIF asynchronous-memory slave that turns each EMIF strobe into
//            one Avalon-MM transaction. WAIT holds the strobe until the
//            Avalon side completes, so the bus latency is absorbed.
// Ports    : clk_i, rst_ni        - clock, asynchronous active-low reset
//            e_addr_i/e_data_i    - EMIF word address / write data
//            e_data_o/e_data_oe_o - EMIF read data / pad output enable
//            e_ben_i, e_cen_i     - byte enables, chip enables (active-low)
//            e_wen_i, e_oen_i     - write / read strobes (active-low)
//            e_wait_o             - 1 = hold strobe, 0 = ready
//            avm                  - Avalon-MM master (emif_avmm_bridge_mcs_if)
//            timeout_o            - sticky Avalon timeout flag
// Options  : EMIF_BRIDGE_TIMEOUT_EN - enables the TIMEOUT_CYC request watchdog;
//            when undefined the bridge waits indefinitely, timeout_o = 0.
// Revision : 1.0 - initial release
// ============================================================================
module emif_avmm_bridge_mcs #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 24,
    parameter int CS_NUM      = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic [ADDR_W-1:0]     e_addr_i,
    input  wire logic [DATA_W-1:0]     e_data_i,
    output logic      [DATA_W-1:0]     e_data_o,
    output logic                       e_data_oe_o,
    input  wire logic [DATA_W/8-1:0]   e_ben_i,
    input  wire logic [CS_NUM-1:0]     e_cen_i,
    input  wire logic                  e_wen_i,
    input  wire logic                  e_oen_i,
    output logic                       e_wait_o,
    emif_avmm_bridge_mcs_if.master     avm,
    output logic                       timeout_o
);
    localparam int BE_W       = DATA_W / 8;
    localparam int CS_W       = (CS_NUM > 1) ? $clog2(CS_NUM) : 0;
    localparam int OFF_W      = $clog2(BE_W);
    localparam int AVM_ADDR_W = CS_W + ADDR_W + OFF_W;
    localparam int S          = SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchronisers. Reset to 1 so a strobe already low at reset
    // release is seen as a fresh falling edge.
    // ------------------------------------------------------------------
    logic [S-1:0]             r_wen_sync;
    logic [S-1:0]             r_oen_sync;
    logic [S-1:0][CS_NUM-1:0] r_cen_sync;
    logic                     r_wen_prev;
    logic                     r_oen_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wen_sync <= '1;
            r_oen_sync <= '1;
            r_cen_sync <= '1;
            r_wen_prev <= 1'b1;
            r_oen_prev <= 1'b1;
        end else begin
            r_wen_sync <= {r_wen_sync[S-2:0], e_wen_i};
            r_oen_sync <= {r_oen_sync[S-2:0], e_oen_i};
            r_cen_sync <= {r_cen_sync[S-2:0], e_cen_i};
            r_wen_prev <= r_wen_sync[S-1];
            r_oen_prev <= r_oen_sync[S-1];
        end
    end

    logic              w_wen_s;
    logic              w_oen_s;
    logic [CS_NUM-1:0] w_cen_s;
    logic              w_cs_hit;
    logic              w_wen_fall;
    logic              w_oen_fall;
    logic [BE_W-1:0]   w_be_req;

    assign w_wen_s    = r_wen_sync[S-1];
    assign w_oen_s    = r_oen_sync[S-1];
    assign w_cen_s    = r_cen_sync[S-1];
    assign w_cs_hit   = ~&w_cen_s;
    assign w_wen_fall = r_wen_prev & ~w_wen_s;
    assign w_oen_fall = r_oen_prev & ~w_oen_s;
    assign w_be_req   = ~e_ben_i;

    // ------------------------------------------------------------------
    // Byte address of the access: {cs_idx, word address, byte offset 0}.
    // The lowest-index active chip enable selects the region.
    // ------------------------------------------------------------------
    logic [AVM_ADDR_W-1:0] w_cap_addr;

    generate
        if (CS_NUM > 1) begin : g_cs_multi
            logic [CS_W-1:0] w_cs_idx;
            always_comb begin
                w_cs_idx = '0;
                for (int i = CS_NUM - 1; i >= 0; i--) begin
                    if (!w_cen_s[i]) w_cs_idx = CS_W'(i);
                end
            end
            assign w_cap_addr = {w_cs_idx, e_addr_i, {OFF_W{1'b0}}};
        end else begin : g_cs_single
            assign w_cap_addr = {e_addr_i, {OFF_W{1'b0}}};
        end
    endgenerate

`ifdef EMIF_BRIDGE_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;
    logic             w_tmo;
    assign w_tmo = (r_tmo_cnt == TMO_LAST);
`endif

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------
    state_t                r_state;
    logic                  r_wait;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_read;
    logic                  r_write;
    logic [AVM_ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]       r_be;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_is_wr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_wait  <= 1'b1;
            r_rdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
`ifdef EMIF_BRIDGE_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef EMIF_BRIDGE_TIMEOUT_EN
            // Counts total cycles spent waiting on the Avalon side.
            if (r_state == S_WR_REQ || r_state == S_RD_REQ || r_state == S_RD_WAIT)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else
                r_tmo_cnt <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    // Write is tested first so it wins a simultaneous fall.
                    if (w_wen_fall && w_cs_hit) begin
                        r_addr  <= w_cap_addr;
                        r_wdata <= e_data_i;
                        r_be    <= w_be_req;
                        r_is_wr <= 1'b1;
                        if (w_be_req == '0) begin
                            // No byte lanes enabled: nothing to write.
                            r_state <= S_HOLD;
                        end else begin
                            r_write <= 1'b1;
                            r_state <= S_WR_REQ;
                        end
                    end else if (w_oen_fall && w_cs_hit) begin
                        r_addr  <= w_cap_addr;
                        r_be    <= '1;
                        r_is_wr <= 1'b0;
                        r_read  <= 1'b1;
                        r_state <= S_RD_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (!avm.avm_waitrequest) begin
                        r_write <= 1'b0;
                        r_state <= S_HOLD;
                    end
`ifdef EMIF_BRIDGE_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_write   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_HOLD;
                    end
`endif
                end
                S_RD_REQ: begin
                    if (!avm.avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
`ifdef EMIF_BRIDGE_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_read    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_rdata   <= {BE_W{8'hDE}};
                        r_state   <= S_HOLD;
                    end
`endif
                end
                S_RD_WAIT: begin
                    if (avm.avm_readdatavalid) begin
                        r_rdata <= avm.avm_readdata;
                        r_state <= S_HOLD;
                    end
`ifdef EMIF_BRIDGE_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_timeout <= 1'b1;
                        r_rdata   <= {BE_W{8'hDE}};
                        r_state   <= S_HOLD;
                    end
`endif
                end
                S_HOLD: begin
                    // Level test of the synchronised strobe: a release that
                    // happened before HOLD was reached is still honoured.
                    if ((r_is_wr && w_wen_s) || (!r_is_wr && w_oen_s)) begin
                        r_wait  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait  <= 1'b0;
                    end
                end
                default: begin
                    r_wait  <= 1'b1;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign avm.avm_address    = r_addr;
    assign avm.avm_read       = r_read;
    assign avm.avm_write      = r_write;
    assign avm.avm_byteenable = r_be;
    assign avm.avm_writedata  = r_wdata;

    assign e_data_o = r_rdata;
    assign e_wait_o = r_wait;

    // Pad direction follows the raw pins for fast bus turnaround.
    assign e_data_oe_o = ~e_oen_i & ~&e_cen_i;

`ifdef EMIF_BRIDGE_TIMEOUT_EN
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/emif_avmm_bridge_mcs.md
# emif_avmm_bridge_mcs

- Synthesizable EMIF asynchronous-memory slave with an Avalon-MM master back end.
- Generalised in data width (16/32) and chip-select count.
- Stretches each EMIF strobe through the WAIT pin until the Avalon transaction completes, so bus latency is absorbed without fixed strobe timing.
- Sits between the DSP EMIF pads and the FPGA interconnect.

## Interface
- DATA_W, 16, EMIF/Avalon data width; 16 or 32. BE_W = DATA_W/8.
- ADDR_W, 24, EMIF word-address width.
- CS_NUM, 1, number of chip selects served (1..4). CS_W = (CS_NUM>1) ? $clog2(CS_NUM) : 0.
- SYNC_STAGES, 2, synchroniser depth for e_cen_i/e_wen_i/e_oen_i (>=2).
- TIMEOUT_CYC, 1024, Avalon timeout in clk cycles. Used only with EMIF_BRIDGE_TIMEOUT_EN.

Ports:
- clk_i in 1: single clock.
- rst_ni in 1: reset, asynchronous, active-low.
- e_addr_i in ADDR_W: EMIF word address.
- e_data_i in DATA_W: EMIF write data.
- e_data_o out DATA_W: EMIF read data.
- e_data_oe_o out 1: pad output enable.
- e_ben_i in BE_W: byte enables, active-low.
- e_cen_i in CS_NUM: chip enables, active-low.
- e_wen_i in 1: write strobe, active-low.
- e_oen_i in 1: read strobe, active-low.
- e_wait_o out 1: WAIT. 1 = hold strobe; 0 = ready.
- avm_address_o out CS_W+ADDR_W+$clog2(BE_W): byte address {cs_idx, e_addr, zeros}.
- avm_read_o, avm_write_o out 1.
- avm_byteenable_o out BE_W.
- avm_writedata_o out DATA_W.
- avm_readdata_i in DATA_W.
- avm_readdatavalid_i in 1.
- avm_waitrequest_i in 1.
- timeout_o out 1: sticky timeout flag; tied 0 without macro.

## Operation
- e_cen_i, e_wen_i and e_oen_i each pass through SYNC_STAGES flops, reset to 1. A falling edge is detected on the synchronised strobe.
- Address, data and byte enables are sampled raw at that detection edge. EMIF setup time guarantees they are stable.
- Chip-select decode: the lowest-index active e_cen_i bit wins and gives cs_idx. No bit active means the strobe is ignored.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, HOLD.
- IDLE:
  - wen fall with cs hit: capture; avm_byteenable_o = ~e_ben_i; go to WR_REQ.
  - oen fall with cs hit: capture; byteenable = all ones; go to RD_REQ.
  - Both strobes falling in the same cycle: write wins.
- WR_REQ: avm_write_o=1 until avm_waitrequest_i=0, then go to HOLD.
  - Special case: if ~e_ben_i == 0, no Avalon write is issued and the FSM goes straight to HOLD.
- RD_REQ: avm_read_o=1 until accepted, then go to RD_WAIT.
- RD_WAIT: on avm_readdatavalid_i, register avm_readdata_i into e_data_o and go to HOLD.
- HOLD: e_wait_o=0. On the synchronised rising edge of the active strobe, set e_wait_o=1 and go to IDLE.
- Strobe falls seen in any state other than IDLE are ignored.
- e_data_oe_o = ~e_oen_i & ~&e_cen_i[CS_NUM-1:0]. This is combinational from the pads for fast turnaround; data is valid only once e_wait_o=0.

## Timing
- Reset values:
  - e_wait_o=1, e_data_o=0, avm_read_o=0, avm_write_o=0, avm_address_o=0, avm_byteenable_o=0, avm_writedata_o=0, timeout_o=0.
  - FSM in IDLE.
- Strobe fall to avm_read_o/avm_write_o high: SYNC_STAGES+1 clk.
- Avalon acceptance (request high with waitrequest low at a clk edge): request drops at that same edge.
- Write: e_wait_o=0 on the clk edge after acceptance.
- Read: e_data_o and e_wait_o=0 update on the edge after avm_readdatavalid_i is sampled.
- Strobe rise to e_wait_o=1: SYNC_STAGES+1 clk.
- Reset mid-operation: all outputs return to their reset values immediately, even if an Avalon request is in flight. A strobe still low when reset releases is serviced as a new access once it has passed the synchronisers.

## Configuration
- EMIF_BRIDGE_TIMEOUT_EN defined:
  - A cycle counter runs in WR_REQ, RD_REQ and RD_WAIT.
  - On reaching TIMEOUT_CYC: drop the Avalon request, set timeout_o=1 (sticky until reset), and go to HOLD.
  - For a timed-out read, e_data_o = {BE_W{8'hDE}}.
- EMIF_BRIDGE_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; timeout_o tied 0.

## Test plan
- DATA_W=16, CS_NUM=1, avm_waitrequest_i=0. Write addr 0x000123, data 0xBEEF, ben 2'b00 -> avm_write_o pulse with avm_address_o=0x000246, byteenable 2'b11, writedata 0xBEEF; e_wait_o=0 two edges later.
- Read same address; slave returns 0xBEEF with avm_readdatavalid_i 5 clk after accept -> e_data_o=0xBEEF and e_wait_o falls on the following edge; e_wait_o back to 1 SYNC_STAGES+1 clk after e_oen_i rises.
- DATA_W=32, CS_NUM=4, e_cen_i=4'b1001 -> cs_idx=1, avm_address_o[MSBs]=2'b01.
- Write with ben all ones -> no avm_write_o; e_wait_o still released.
- avm_waitrequest_i held 1 with the macro defined, TIMEOUT_CYC=16 -> request drops after 16 clk, timeout_o=1, read returns 0xDEDE.
- Assert rst_ni in RD_WAIT -> avm_read_o=0, e_wait_o=1 at once. Hold e_oen_i low across reset release -> a new read is issued after SYNC_STAGES+1 clk.
